// File: rtl/cr_su_arb_pkg.sv
// Shared types for the SU schedule-update arbiter.
// The record layout matches the one consumed by the SU input FIFO.
package cr_su_arb_pkg;

   typedef enum logic {
      ARB_IDLE,
      ARB_LOCK
   } su_arb_st_e;

   // su_ready promises this many free slots, covering records still in flight
   localparam int unsigned SU_ARB_READY_MARGIN = 8;

   typedef struct packed {
      logic        valid;
      logic        last;
      logic [7:0]  queue_id;
      logic [31:0] data;
   } sched_update_if_bus_t;

endpackage

// File: rtl/cr_su_arb_rr.sv
// Round-robin priority picker: first set request after ptr, scanning upward
// modulo N_REQ.
module cr_su_arb_rr #(
   parameter int unsigned N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic [N_REQ-1:0]         gnt,
   output logic [$clog2(N_REQ)-1:0] idx,
   output logic                     any
);

   localparam int unsigned IW = $clog2(N_REQ);

   int unsigned          cand;
   logic [IW-1:0]        cand_idx;

   always_comb begin
      gnt      = '0;
      idx      = '0;
      any      = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         cand     = (32'(ptr) + k) % N_REQ;
         cand_idx = IW'(cand);
         if (!any && req[cand_idx]) begin
            any           = 1'b1;
            idx           = cand_idx;
            gnt[cand_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cr_su_arb.sv
// Round-robin arbiter in front of the SU input FIFO; multi-record sequences
// lock the grant to their owner until last=1 or an idle timeout.
module cr_su_arb
   import cr_su_arb_pkg::*;
#(
   parameter int unsigned N_REQ        = 4,
   parameter int unsigned LOCK_TIMEOUT = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  sched_update_if_bus_t     req_in [N_REQ],
   output logic [N_REQ-1:0]         req_ack,
   input  logic                     su_ready,
   output sched_update_if_bus_t     su_in,
   output logic [$clog2(N_REQ)-1:0] grant_owner,
   output logic                     arb_locked,
   output logic [N_REQ-1:0]         grant_stb,
   output logic                     lock_timeout_err
);

   localparam int unsigned IW       = $clog2(N_REQ);
   localparam logic [15:0] IDLE_MAX = 16'(LOCK_TIMEOUT - 1);

   su_arb_st_e           state_q;
   logic [IW-1:0]        rr_ptr_q;
   logic [15:0]          idle_cnt_q;

   logic [N_REQ-1:0]     req_valid;
   logic [N_REQ-1:0]     pick_gnt;
   logic [N_REQ-1:0]     owner_oh;
   logic [IW-1:0]        pick_idx;
   logic [IW-1:0]        win_idx;
   logic                 pick_any;
   logic                 win_valid;
   logic                 accept;
   sched_update_if_bus_t win_rec;

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         req_valid[i] = req_in[i].valid;
      end
   end

   cr_su_arb_rr #(
      .N_REQ (N_REQ)
   ) u_rr (
      .req (req_valid),
      .ptr (rr_ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   // Grant decision uses only valid bits and registered state, never record data.
   always_comb begin
      owner_oh              = '0;
      owner_oh[grant_owner] = 1'b1;
      if (state_q == ARB_LOCK) begin
         win_idx   = grant_owner;
         win_valid = req_valid[grant_owner];
      end else begin
         win_idx   = pick_idx;
         win_valid = pick_any;
      end
      accept  = !rst && su_ready && win_valid;
      req_ack = '0;
      if (accept) begin
         req_ack = (state_q == ARB_LOCK) ? owner_oh : pick_gnt;
      end
   end

   assign win_rec    = req_in[win_idx];
   assign arb_locked = (state_q == ARB_LOCK);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= ARB_IDLE;
         rr_ptr_q         <= IW'(N_REQ - 1);
         idle_cnt_q       <= '0;
         su_in            <= '0;
         grant_owner      <= '0;
         grant_stb        <= '0;
         lock_timeout_err <= 1'b0;
      end else begin
         grant_stb        <= '0;
         lock_timeout_err <= 1'b0;
         su_in.valid      <= 1'b0;
         if (accept) begin
            su_in       <= win_rec;
            su_in.valid <= 1'b1;
            grant_owner <= win_idx;
            idle_cnt_q  <= '0;
            if (win_rec.last) begin
               state_q   <= ARB_IDLE;
               rr_ptr_q  <= win_idx;
               grant_stb <= req_ack;
            end else begin
               state_q <= ARB_LOCK;
            end
         end else if (state_q == ARB_LOCK && !win_valid) begin
            // Owner went quiet: release so other requesters are not starved.
            if (idle_cnt_q == IDLE_MAX) begin
               lock_timeout_err <= 1'b1;
               state_q          <= ARB_IDLE;
               rr_ptr_q         <= grant_owner;
               idle_cnt_q       <= '0;
            end else begin
               idle_cnt_q <= idle_cnt_q + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_cr_su_arb.sv
// Bench for cr_su_arb: directed scenarios plus a randomized run against a
// cycle-level reference model of the arbitration rules.
module tb_cr_su_arb;
   import cr_su_arb_pkg::*;

   localparam int N  = 4;
   localparam int TO = 16;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 su_ready;
   sched_update_if_bus_t req_in [N];
   logic [N-1:0]         req_ack;
   sched_update_if_bus_t su_in;
   logic [1:0]           grant_owner;
   logic                 arb_locked;
   logic [N-1:0]         grant_stb;
   logic                 lock_timeout_err;

   cr_su_arb #(
      .N_REQ        (N),
      .LOCK_TIMEOUT (TO)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .req_in           (req_in),
      .req_ack          (req_ack),
      .su_ready         (su_ready),
      .su_in            (su_in),
      .grant_owner      (grant_owner),
      .arb_locked       (arb_locked),
      .grant_stb        (grant_stb),
      .lock_timeout_err (lock_timeout_err)
   );

   always #5 clk = ~clk;

   int n_chk;
   int n_pass;

   sched_update_if_bus_t src_q [N][$];
   int                   seq_no [N];

   // Reference model state
   logic                 m_locked;
   int                   m_owner;
   int                   m_rr;
   int                   m_idle;
   int                   m_w;
   logic [N-1:0]         m_ack;
   sched_update_if_bus_t exp_su;
   logic [N-1:0]         exp_stb;
   logic                 exp_err;
   int                   exp_owner;

   task automatic push_rec(input int i, input logic last);
      sched_update_if_bus_t r;
      r.valid    = 1'b1;
      r.last     = last;
      r.queue_id = 8'(i);
      r.data     = {8'(i), 24'(seq_no[i])};
      seq_no[i]++;
      src_q[i].push_back(r);
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         if (src_q[i].size() > 0) begin
            req_in[i]       = src_q[i][0];
            req_in[i].valid = 1'b1;
         end else begin
            req_in[i] = '0;
         end
      end
   endtask

   task automatic clear_sources();
      for (int i = 0; i < N; i++) begin
         src_q[i].delete();
         seq_no[i] = 0;
      end
   endtask

   // Who should be consumed this cycle, from the arbitration rules.
   task automatic model_eval();
      m_w   = -1;
      m_ack = '0;
      if (!rst && su_ready) begin
         if (m_locked) begin
            if (req_in[m_owner].valid) m_w = m_owner;
         end else begin
            for (int k = 1; k <= N; k++) begin
               if (m_w < 0 && req_in[(m_rr + k) % N].valid) m_w = (m_rr + k) % N;
            end
         end
         if (m_w >= 0) m_ack[m_w] = 1'b1;
      end
   endtask

   task automatic model_commit();
      if (rst) begin
         m_locked  = 1'b0;
         m_owner   = 0;
         m_rr      = N - 1;
         m_idle    = 0;
         exp_su    = '0;
         exp_stb   = '0;
         exp_err   = 1'b0;
         exp_owner = 0;
      end else begin
         exp_stb      = '0;
         exp_err      = 1'b0;
         exp_su.valid = 1'b0;
         if (m_w >= 0) begin
            exp_su    = req_in[m_w];
            exp_owner = m_w;
            m_idle    = 0;
            if (req_in[m_w].last) begin
               m_locked      = 1'b0;
               m_rr          = m_w;
               exp_stb[m_w]  = 1'b1;
            end else begin
               m_locked = 1'b1;
               m_owner  = m_w;
            end
            if (src_q[m_w].size() > 0) void'(src_q[m_w].pop_front());
         end else if (m_locked && !req_in[m_owner].valid) begin
            if (m_idle == TO - 1) begin
               exp_err  = 1'b1;
               m_locked = 1'b0;
               m_rr     = m_owner;
               m_idle   = 0;
            end else begin
               m_idle++;
            end
         end
      end
   endtask

   task automatic settle();
      @(negedge clk);
      model_eval();
   endtask

   task automatic advance(input logic rdy, input logic r);
      model_commit();
      @(posedge clk);
      #1;
      su_ready = rdy;
      rst      = r;
      drive_inputs();
   endtask

   task automatic do_reset();
      clear_sources();
      rst      = 1'b1;
      su_ready = 1'b1;
      drive_inputs();
      settle();
      advance(1'b1, 1'b0);
   endtask

   task automatic test_reset();
      clear_sources();
      for (int i = 0; i < N; i++) push_rec(i, 1'b1);
      rst      = 1'b1;
      su_ready = 1'b1;
      drive_inputs();
      settle();
      n_chk++;
      if (req_ack !== 4'b0000) $display("FAIL reset_ack: got %b want 0000", req_ack);
      else n_pass++;
      advance(1'b1, 1'b1);
      settle();
      n_chk++;
      if (su_in !== '0) $display("FAIL reset_su_in: got %h want 0", su_in);
      else n_pass++;
      n_chk++;
      if (grant_owner !== 2'd0) $display("FAIL reset_owner: got %0d want 0", grant_owner);
      else n_pass++;
      n_chk++;
      if (arb_locked !== 1'b0 || grant_stb !== 4'b0000 || lock_timeout_err !== 1'b0)
         $display("FAIL reset_flags: got locked=%b stb=%b err=%b want 0 0000 0",
                  arb_locked, grant_stb, lock_timeout_err);
      else n_pass++;
      advance(1'b1, 1'b0);
      settle();
      n_chk++;
      if (req_ack !== 4'b0001) $display("FAIL reset_first_prio: got %b want 0001", req_ack);
      else n_pass++;
      advance(1'b1, 1'b0);
   endtask

   task automatic test_round_robin();
      int stb_cnt [N];
      do_reset();
      for (int i = 0; i < N; i++) begin
         push_rec(i, 1'b1);
         stb_cnt[i] = 0;
      end
      drive_inputs();
      for (int t = 0; t < 6; t++) begin
         settle();
         if (t < 4) begin
            n_chk++;
            if (req_ack !== 4'(1 << t)) $display("FAIL rr_ack t=%0d: got %b want %b",
                                                 t, req_ack, 4'(1 << t));
            else n_pass++;
         end
         if (t >= 1 && t <= 4) begin
            n_chk++;
            if (su_in.valid !== 1'b1 || su_in.data[31:24] !== 8'(t - 1))
               $display("FAIL rr_su_in t=%0d: got v=%b src=%0d want v=1 src=%0d",
                        t, su_in.valid, su_in.data[31:24], t - 1);
            else n_pass++;
            n_chk++;
            if (grant_stb !== 4'(1 << (t - 1)))
               $display("FAIL rr_stb t=%0d: got %b want %b", t, grant_stb, 4'(1 << (t - 1)));
            else n_pass++;
         end
         for (int i = 0; i < N; i++) stb_cnt[i] += int'(grant_stb[i]);
         advance(1'b1, 1'b0);
      end
      for (int i = 0; i < N; i++) begin
         n_chk++;
         if (stb_cnt[i] != 1) $display("FAIL rr_stb_count[%0d]: got %0d want 1", i, stb_cnt[i]);
         else n_pass++;
      end
   endtask

   task automatic test_lock();
      do_reset();
      push_rec(2, 1'b0);
      push_rec(2, 1'b0);
      push_rec(2, 1'b1);
      drive_inputs();
      settle();
      n_chk++;
      if (req_ack !== 4'b0100) $display("FAIL lock_first: got %b want 0100", req_ack);
      else n_pass++;
      for (int k = 0; k < 4; k++) push_rec(0, 1'b1);
      advance(1'b1, 1'b0);
      for (int t = 1; t <= 2; t++) begin
         settle();
         n_chk++;
         if (req_ack !== 4'b0100) $display("FAIL lock_hold t=%0d: got %b want 0100", t, req_ack);
         else n_pass++;
         n_chk++;
         if (arb_locked !== 1'b1 || grant_owner !== 2'd2)
            $display("FAIL lock_state t=%0d: got locked=%b owner=%0d want 1 2",
                     t, arb_locked, grant_owner);
         else n_pass++;
         advance(1'b1, 1'b0);
      end
      settle();
      n_chk++;
      if (req_ack !== 4'b0001) $display("FAIL lock_release_next: got %b want 0001", req_ack);
      else n_pass++;
      n_chk++;
      if (su_in.valid !== 1'b1 || su_in.data !== {8'd2, 24'd2} || grant_stb !== 4'b0100
          || arb_locked !== 1'b0)
         $display("FAIL lock_last_out: got v=%b data=%h stb=%b locked=%b want 1 02000002 0100 0",
                  su_in.valid, su_in.data, grant_stb, arb_locked);
      else n_pass++;
      advance(1'b1, 1'b0);
      settle();
      n_chk++;
      if (su_in.valid !== 1'b1 || su_in.data !== {8'd0, 24'd0})
         $display("FAIL lock_next_out: got v=%b data=%h want 1 00000000", su_in.valid, su_in.data);
      else n_pass++;
      advance(1'b1, 1'b0);
   endtask

   task automatic test_stall();
      logic [31:0] got [$];
      logic [31:0] want;
      do_reset();
      for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push_rec(i, 1'b1);
      drive_inputs();
      for (int t = 0; t < 16; t++) begin
         settle();
         if (t >= 2 && t < 7) begin
            n_chk++;
            if (req_ack !== 4'b0000) $display("FAIL stall_ack t=%0d: got %b want 0000", t, req_ack);
            else n_pass++;
         end
         if (t >= 3 && t <= 7) begin
            n_chk++;
            if (su_in.valid !== 1'b0) $display("FAIL stall_su_in t=%0d: got v=%b want 0",
                                               t, su_in.valid);
            else n_pass++;
         end
         if (t == 7) begin
            n_chk++;
            if (req_ack !== 4'b0100) $display("FAIL stall_resume: got %b want 0100", req_ack);
            else n_pass++;
         end
         if (su_in.valid === 1'b1) got.push_back(su_in.data);
         advance(!((t + 1) >= 2 && (t + 1) < 7), 1'b0);
      end
      n_chk++;
      if (got.size() != 8) $display("FAIL stall_count: got %0d want 8", got.size());
      else n_pass++;
      for (int k = 0; k < got.size() && k < 8; k++) begin
         want = {8'(k % 4), 24'(k / 4)};
         n_chk++;
         if (got[k] !== want) $display("FAIL stall_order[%0d]: got %h want %h", k, got[k], want);
         else n_pass++;
      end
   endtask

   task automatic test_timeout();
      do_reset();
      push_rec(1, 1'b0);
      push_rec(3, 1'b1);
      drive_inputs();
      settle();
      n_chk++;
      if (req_ack !== 4'b0010) $display("FAIL to_first: got %b want 0010", req_ack);
      else n_pass++;
      advance(1'b1, 1'b0);
      for (int t = 1; t <= 16; t++) begin
         settle();
         n_chk++;
         if (req_ack !== 4'b0000 || lock_timeout_err !== 1'b0 || arb_locked !== 1'b1)
            $display("FAIL to_wait t=%0d: got ack=%b err=%b locked=%b want 0000 0 1",
                     t, req_ack, lock_timeout_err, arb_locked);
         else n_pass++;
         advance(1'b1, 1'b0);
      end
      settle();
      n_chk++;
      if (lock_timeout_err !== 1'b1 || arb_locked !== 1'b0)
         $display("FAIL to_pulse: got err=%b locked=%b want 1 0", lock_timeout_err, arb_locked);
      else n_pass++;
      n_chk++;
      if (req_ack !== 4'b1000) $display("FAIL to_next_winner: got %b want 1000", req_ack);
      else n_pass++;
      advance(1'b1, 1'b0);
      settle();
      n_chk++;
      if (lock_timeout_err !== 1'b0 || su_in.valid !== 1'b1 || su_in.data !== {8'd3, 24'd0})
         $display("FAIL to_after: got err=%b v=%b data=%h want 0 1 03000000",
                  lock_timeout_err, su_in.valid, su_in.data);
      else n_pass++;
      advance(1'b1, 1'b0);
   endtask

   task automatic test_reset_lock();
      do_reset();
      push_rec(2, 1'b0);
      push_rec(2, 1'b0);
      push_rec(2, 1'b1);
      drive_inputs();
      settle();
      advance(1'b1, 1'b0);
      settle();
      n_chk++;
      if (arb_locked !== 1'b1) $display("FAIL rstlock_locked: got %b want 1", arb_locked);
      else n_pass++;
      advance(1'b1, 1'b1);
      clear_sources();
      for (int i = 0; i < N; i++) push_rec(i, 1'b1);
      drive_inputs();
      settle();
      n_chk++;
      if (req_ack !== 4'b0000) $display("FAIL rstlock_ack: got %b want 0000", req_ack);
      else n_pass++;
      advance(1'b1, 1'b0);
      settle();
      n_chk++;
      if (arb_locked !== 1'b0 || su_in.valid !== 1'b0 || req_ack !== 4'b0001)
         $display("FAIL rstlock_after: got locked=%b v=%b ack=%b want 0 0 0001",
                  arb_locked, su_in.valid, req_ack);
      else n_pass++;
      advance(1'b1, 1'b0);
   endtask

   task automatic test_random();
      int push_pct;
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         settle();
         n_chk++;
         if (req_ack !== m_ack) $display("FAIL rand_ack c=%0d: got %b want %b", c, req_ack, m_ack);
         else n_pass++;
         n_chk++;
         if (su_in.valid !== exp_su.valid || (exp_su.valid && su_in !== exp_su))
            $display("FAIL rand_su_in c=%0d: got %h want %h", c, su_in, exp_su);
         else n_pass++;
         n_chk++;
         if (grant_stb !== exp_stb) $display("FAIL rand_stb c=%0d: got %b want %b",
                                             c, grant_stb, exp_stb);
         else n_pass++;
         n_chk++;
         if (lock_timeout_err !== exp_err) $display("FAIL rand_err c=%0d: got %b want %b",
                                                    c, lock_timeout_err, exp_err);
         else n_pass++;
         n_chk++;
         if (arb_locked !== m_locked || grant_owner !== 2'(exp_owner))
            $display("FAIL rand_state c=%0d: got locked=%b owner=%0d want %b %0d",
                     c, arb_locked, grant_owner, m_locked, exp_owner);
         else n_pass++;
         push_pct = (c < 1000) ? 40 : 6;
         for (int i = 0; i < N; i++) begin
            if (src_q[i].size() < 3 && $urandom_range(0, 99) < push_pct)
               push_rec(i, 1'($urandom_range(0, 1)));
         end
         advance($urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0);
      end
   endtask

   initial begin
      n_chk    = 0;
      n_pass   = 0;
      rst      = 1'b1;
      su_ready = 1'b1;
      for (int i = 0; i < N; i++) req_in[i] = '0;
      m_locked  = 1'b0;
      m_owner   = 0;
      m_rr      = N - 1;
      m_idle    = 0;
      m_w       = -1;
      m_ack     = '0;
      exp_su    = '0;
      exp_stb   = '0;
      exp_err   = 1'b0;
      exp_owner = 0;
      test_reset();
      test_round_robin();
      test_lock();
      test_stall();
      test_timeout();
      test_reset_lock();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
